// File: rtl/bcd_seg7_scan_driver.sv
// bcd_seg7_scan_driver: two-digit multiplexed 7-segment scanner.
// Shadow/active digit copies, frame-aligned commit, dead-time gaps.
module bcd_seg7_scan_driver #(
  parameter int REFRESH_DIV        = 1000,
  parameter int BLANK_CYCLES       = 16,
  parameter bit BLANK_LEADING_ZERO = 1'b1,
  parameter bit SEG_ACTIVE_LOW     = 1'b0,
  parameter bit DIG_ACTIVE_LOW     = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       load,
  input  logic [3:0] digit1_in,
  input  logic [3:0] digit0_in,
  output logic [6:0] seg_out,
  output logic [1:0] dig_sel,
  output logic       frame_done
);

  localparam int MAX_CNT =
    (REFRESH_DIV > BLANK_CYCLES) ?
    REFRESH_DIV : BLANK_CYCLES;
  localparam int TW = $clog2(MAX_CNT + 1);

  localparam bit HAS_GAP = (BLANK_CYCLES > 0);

  localparam logic [TW-1:0] SHOW_LAST =
    TW'(REFRESH_DIV - 1);
  localparam logic [TW-1:0] GAP_LAST =
    TW'(HAS_GAP ? BLANK_CYCLES - 1 : 0);

  localparam logic [6:0] SEG_OFF =
    SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0] DIG_OFF =
    DIG_ACTIVE_LOW ? 2'b11 : 2'b00;

  typedef enum logic [2:0] {
    S_OFF,
    S_SHOW0,
    S_GAP0,
    S_SHOW1,
    S_GAP1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;
  logic [7:0]    shadow;
  logic [7:0]    active;
  logic [7:0]    active_nxt;
  logic          show_end;
  logic          gap_end;
  logic          frame_start;
  logic          frame_wrap;
  logic [6:0]    seg_raw;
  logic [1:0]    dig_raw;
  logic [6:0]    seg_nxt;
  logic [1:0]    dig_nxt;
  logic          tens_blank;

  function automatic logic [6:0] decode(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // next-state sequencing; enable low forces the display dark
  always_comb begin
    state_nxt = state;
    show_end  = (timer == SHOW_LAST);
    gap_end   = (timer == GAP_LAST);
    unique case (state)
      S_OFF:   state_nxt = S_SHOW0;
      S_SHOW0: begin
        if (show_end)
          state_nxt = HAS_GAP ? S_GAP0 : S_SHOW1;
      end
      S_GAP0: begin
        if (gap_end)
          state_nxt = S_SHOW1;
      end
      S_SHOW1: begin
        if (show_end)
          state_nxt = HAS_GAP ? S_GAP1 : S_SHOW0;
      end
      S_GAP1: begin
        if (gap_end)
          state_nxt = S_SHOW0;
      end
      default: state_nxt = S_OFF;
    endcase
    if (!enable)
      state_nxt = S_OFF;
  end

  // frame boundary detection and digit commit
  always_comb begin
    frame_start = (state_nxt == S_SHOW0) &&
                  (state != S_SHOW0);
    frame_wrap  = frame_start && (state != S_OFF);
    timer_nxt   = (state_nxt != state) ?
                  '0 : timer + TW'(1);
    active_nxt  = active;
    if (frame_start)
      active_nxt = load ?
        {digit1_in, digit0_in} : shadow;
  end

  // output image for the state being entered
  always_comb begin
    seg_raw    = 7'h00;
    dig_raw    = 2'b00;
    tens_blank = BLANK_LEADING_ZERO &&
                 (active_nxt[7:4] == 4'd0);
    unique case (state_nxt)
      S_SHOW0: begin
        seg_raw = decode(active_nxt[3:0]);
        dig_raw = 2'b01;
      end
      S_SHOW1: begin
        if (!tens_blank) begin
          seg_raw = decode(active_nxt[7:4]);
          dig_raw = 2'b10;
        end
      end
      default: begin
        seg_raw = 7'h00;
        dig_raw = 2'b00;
      end
    endcase
    seg_nxt = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    dig_nxt = DIG_ACTIVE_LOW ? ~dig_raw : dig_raw;
  end

  // shadow capture runs regardless of scan state
  always_ff @(posedge clk) begin
    if (rst)
      shadow <= '0;
    else if (load)
      shadow <= {digit1_in, digit0_in};
  end

  // scan FSM, committed digits and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_OFF;
      timer      <= '0;
      active     <= '0;
      seg_out    <= SEG_OFF;
      dig_sel    <= DIG_OFF;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      active     <= active_nxt;
      seg_out    <= seg_nxt;
      dig_sel    <= dig_nxt;
      frame_done <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_bcd_seg7_scan_driver.sv
// tb_bcd_seg7_scan_driver: scoreboard bench for the 7-seg scanner.
// Four instances share stimulus: base, no-blank, inverted, no-gap.
module tb_bcd_seg7_scan_driver;

  typedef struct packed {
    logic [6:0] seg;
    logic [1:0] dig;
    logic       fd;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       load = 1'b0;
  logic [3:0] digit1_in = 4'd0;
  logic [3:0] digit0_in = 4'd0;

  logic [6:0] seg_a, seg_b, seg_c, seg_d;
  logic [1:0] dig_a, dig_b, dig_c, dig_d;
  logic       fd_a, fd_b, fd_c, fd_d;

  obs_t sb[$];
  obs_t sb_b[$];
  obs_t sb_d[$];

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bcd_seg7_scan_driver #(
    .REFRESH_DIV(4), .BLANK_CYCLES(2)
  ) u_a (
    .clk(clk), .rst(rst), .enable(enable),
    .load(load), .digit1_in(digit1_in),
    .digit0_in(digit0_in), .seg_out(seg_a),
    .dig_sel(dig_a), .frame_done(fd_a)
  );

  bcd_seg7_scan_driver #(
    .REFRESH_DIV(4), .BLANK_CYCLES(2),
    .BLANK_LEADING_ZERO(1'b0)
  ) u_b (
    .clk(clk), .rst(rst), .enable(enable),
    .load(load), .digit1_in(digit1_in),
    .digit0_in(digit0_in), .seg_out(seg_b),
    .dig_sel(dig_b), .frame_done(fd_b)
  );

  bcd_seg7_scan_driver #(
    .REFRESH_DIV(4), .BLANK_CYCLES(2),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) u_c (
    .clk(clk), .rst(rst), .enable(enable),
    .load(load), .digit1_in(digit1_in),
    .digit0_in(digit0_in), .seg_out(seg_c),
    .dig_sel(dig_c), .frame_done(fd_c)
  );

  bcd_seg7_scan_driver #(
    .REFRESH_DIV(4), .BLANK_CYCLES(0)
  ) u_d (
    .clk(clk), .rst(rst), .enable(enable),
    .load(load), .digit1_in(digit1_in),
    .digit0_in(digit0_in), .seg_out(seg_d),
    .dig_sel(dig_d), .frame_done(fd_d)
  );

  task automatic push(
    input int which, input int n,
    input logic [6:0] s, input logic [1:0] d,
    input logic f1
  );
    obs_t e;
    for (int i = 0; i < n; i++) begin
      e.seg = s;
      e.dig = d;
      e.fd  = (i == 0) ? f1 : 1'b0;
      if (which == 0) sb.push_back(e);
      else if (which == 1) sb_b.push_back(e);
      else sb_d.push_back(e);
    end
  endtask

  task automatic push_frame(
    input int which, input logic [6:0] u,
    input logic [6:0] t, input logic [1:0] td,
    input logic f
  );
    push(which, 4, u, 2'b01, f);
    push(which, 2, 7'h00, 2'b00, 1'b0);
    push(which, 4, t, td, 1'b0);
    push(which, 2, 7'h00, 2'b00, 1'b0);
  endtask

  task automatic set_in(
    input logic r, input logic en,
    input logic ld, input logic [7:0] d
  );
    rst = r;
    enable = en;
    load = ld;
    {digit1_in, digit0_in} = d;
  endtask

  task automatic do_reset();
    sb.delete();
    sb_b.delete();
    sb_d.delete();
    set_in(1'b1, 1'b0, 1'b0, 8'h00);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    obs_t e, ec;
    sb.delete();
    push(0, 5, 7'h00, 2'b00, 1'b0);
    push(0, 4, 7'h06, 2'b01, 1'b0);
    push(0, 2, 7'h00, 2'b00, 1'b0);
    push(0, 4, 7'h6F, 2'b10, 1'b0);
    push(0, 2, 7'h00, 2'b00, 1'b0);
    for (int c = 1; c <= 17; c++) begin
      set_in(c <= 2, c >= 6, c == 4, 8'h91);
      @(posedge clk); #1;
      e = sb.pop_front();
      ec = {~e.seg, ~e.dig, e.fd};
      n_run++;
      if ({seg_a, dig_a, fd_a} !== e) begin
        n_fail++;
        $display("FAIL reset_a c%0d: got %h want %h",
          c, {seg_a, dig_a, fd_a}, e);
      end
      n_run++;
      if ({seg_c, dig_c, fd_c} !== ec) begin
        n_fail++;
        $display("FAIL reset_c c%0d: got %h want %h",
          c, {seg_c, dig_c, fd_c}, ec);
      end
    end
  endtask

  task automatic test_frame();
    obs_t e, ec, ed;
    do_reset();
    push_frame(0, 7'h5B, 7'h66, 2'b10, 1'b0);
    push_frame(0, 7'h5B, 7'h66, 2'b10, 1'b1);
    push(2, 4, 7'h5B, 2'b01, 1'b0);
    push(2, 4, 7'h66, 2'b10, 1'b0);
    for (int k = 0; k < 2; k++) begin
      push(2, 4, 7'h5B, 2'b01, 1'b1);
      push(2, 4, 7'h66, 2'b10, 1'b0);
    end
    for (int c = 1; c <= 24; c++) begin
      set_in(1'b0, 1'b1, c == 1, 8'h42);
      @(posedge clk); #1;
      e = sb.pop_front();
      ec = {~e.seg, ~e.dig, e.fd};
      ed = sb_d.pop_front();
      n_run++;
      if ({seg_a, dig_a, fd_a} !== e) begin
        n_fail++;
        $display("FAIL frame_a c%0d: got %h want %h",
          c, {seg_a, dig_a, fd_a}, e);
      end
      n_run++;
      if ({seg_c, dig_c, fd_c} !== ec) begin
        n_fail++;
        $display("FAIL frame_c c%0d: got %h want %h",
          c, {seg_c, dig_c, fd_c}, ec);
      end
      n_run++;
      if ({seg_d, dig_d, fd_d} !== ed) begin
        n_fail++;
        $display("FAIL nogap_d c%0d: got %h want %h",
          c, {seg_d, dig_d, fd_d}, ed);
      end
    end
  endtask

  task automatic test_leading_zero();
    obs_t e, eb;
    do_reset();
    push_frame(0, 7'h07, 7'h00, 2'b00, 1'b0);
    push_frame(1, 7'h07, 7'h3F, 2'b10, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      set_in(1'b0, 1'b1, c == 1, 8'h07);
      @(posedge clk); #1;
      e = sb.pop_front();
      eb = sb_b.pop_front();
      n_run++;
      if ({seg_a, dig_a, fd_a} !== e) begin
        n_fail++;
        $display("FAIL lz_a c%0d: got %h want %h",
          c, {seg_a, dig_a, fd_a}, e);
      end
      n_run++;
      if ({seg_b, dig_b, fd_b} !== eb) begin
        n_fail++;
        $display("FAIL lz_b c%0d: got %h want %h",
          c, {seg_b, dig_b, fd_b}, eb);
      end
    end
  endtask

  task automatic test_shadow();
    obs_t e;
    logic [7:0] d;
    do_reset();
    push_frame(0, 7'h5B, 7'h66, 2'b10, 1'b0);
    push_frame(0, 7'h6D, 7'h06, 2'b10, 1'b1);
    push_frame(0, 7'h7F, 7'h4F, 2'b10, 1'b1);
    for (int c = 1; c <= 36; c++) begin
      d = (c == 1) ? 8'h42 :
          (c == 8) ? 8'h15 : 8'h38;
      set_in(1'b0, 1'b1,
        c == 1 || c == 8 || c == 25, d);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_run++;
      if ({seg_a, dig_a, fd_a} !== e) begin
        n_fail++;
        $display("FAIL shadow_a c%0d: got %h want %h",
          c, {seg_a, dig_a, fd_a}, e);
      end
    end
  endtask

  task automatic test_dash_polarity();
    obs_t e, ec;
    do_reset();
    push_frame(0, 7'h40, 7'h40, 2'b10, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      set_in(1'b0, 1'b1, c == 1, 8'hAF);
      @(posedge clk); #1;
      e = sb.pop_front();
      ec = {~e.seg, ~e.dig, e.fd};
      n_run++;
      if ({seg_a, dig_a, fd_a} !== e) begin
        n_fail++;
        $display("FAIL dash_a c%0d: got %h want %h",
          c, {seg_a, dig_a, fd_a}, e);
      end
      n_run++;
      if ({seg_c, dig_c, fd_c} !== ec) begin
        n_fail++;
        $display("FAIL pol_c c%0d: got %h want %h",
          c, {seg_c, dig_c, fd_c}, ec);
      end
    end
  endtask

  task automatic test_enable_reset();
    obs_t e, ec;
    do_reset();
    push(0, 4, 7'h5B, 2'b01, 1'b0);
    push(0, 2, 7'h00, 2'b00, 1'b0);
    push(0, 1, 7'h66, 2'b10, 1'b0);
    push(0, 2, 7'h00, 2'b00, 1'b0);
    push(0, 4, 7'h5B, 2'b01, 1'b0);
    push(0, 2, 7'h00, 2'b00, 1'b0);
    push(0, 4, 7'h3F, 2'b01, 1'b0);
    push(0, 2, 7'h00, 2'b00, 1'b0);
    push(0, 4, 7'h00, 2'b00, 1'b0);
    push(0, 2, 7'h00, 2'b00, 1'b0);
    push(0, 1, 7'h3F, 2'b01, 1'b1);
    for (int c = 1; c <= 28; c++) begin
      set_in(c == 15, !(c == 8 || c == 9),
        c == 1, 8'h42);
      @(posedge clk); #1;
      e = sb.pop_front();
      ec = {~e.seg, ~e.dig, e.fd};
      n_run++;
      if ({seg_a, dig_a, fd_a} !== e) begin
        n_fail++;
        $display("FAIL en_a c%0d: got %h want %h",
          c, {seg_a, dig_a, fd_a}, e);
      end
      n_run++;
      if ({seg_c, dig_c, fd_c} !== ec) begin
        n_fail++;
        $display("FAIL en_c c%0d: got %h want %h",
          c, {seg_c, dig_c, fd_c}, ec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_leading_zero();
    test_shadow();
    test_dash_polarity();
    test_enable_reset();
    $display("[TB] %0d tests run, %0d failed",
      n_run, n_fail);
    $finish;
  end

endmodule
